// File: rtl/seg7_scan_n_if.sv
// Display bundle for seg7_scan_n: the register-file side (digits, DPs, load,
// blanking controls) and the board side (static buses and the scan bus).
// The slave modport is the driver block; the master modport is its user.
interface seg7_scan_n_if #(
  parameter int DIGITS = 4
);

  logic [4*DIGITS-1:0] i_dig;
  logic [DIGITS-1:0]   i_dp;
  logic                i_load;
  logic                i_blankLz;
  logic [DIGITS-1:0]   i_blink;

  logic [7*DIGITS-1:0] o_seg;
  logic [DIGITS-1:0]   o_dp;
  logic [6:0]          o_scanSeg;
  logic                o_scanDp;
  logic [DIGITS-1:0]   o_scanSel;
  logic                o_frame;

  modport master (
    output i_dig, i_dp, i_load, i_blankLz, i_blink,
    input  o_seg, o_dp, o_scanSeg, o_scanDp, o_scanSel, o_frame
  );

  modport slave (
    input  i_dig, i_dp, i_load, i_blankLz, i_blink,
    output o_seg, o_dp, o_scanSeg, o_scanDp, o_scanSel, o_frame
  );

endinterface

// File: rtl/seg7_scan_n.sv
// N-digit hex 7-segment driver. A display word is captured on a load strobe
// and shown two ways: registered per-digit static buses that follow the held
// word with one cycle of latency, and a time-multiplexed scan bus that works
// from a per-frame copy so a frame never mixes two words. Both views apply
// the same leading-zero blanking and per-digit blink rules. All outputs are
// active-low, segments ordered g..a.
module seg7_scan_n #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int DEAD      = 500,
  parameter int BLINK_DIV = 25000000
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  seg7_scan_n_if.slave io_disp
);

  // Counter widths; each counter is at least one bit wide so DIGITS=1 and
  // BLINK_DIV=1 still elaborate.
  localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int IW = (DIGITS    > 1) ? $clog2(DIGITS)    : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SLOT_DEAD  = SW'(DEAD);
  localparam logic [SW-1:0] SLOT_ONE   = SW'(1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [IW-1:0] IDX_ONE    = IW'(1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [BW-1:0] BLINK_ONE  = BW'(1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Held word (follows iLOAD) and the frame copy the scan bus reads from.
  logic [4*DIGITS-1:0] r_heldDig;
  logic [DIGITS-1:0]   r_heldDp;
  logic [4*DIGITS-1:0] r_frameDig;
  logic [DIGITS-1:0]   r_frameDp;

  // Scan position and blink timebase.
  logic [SW-1:0] r_slot;
  logic [IW-1:0] r_idx;
  logic [BW-1:0] r_blinkCnt;
  logic          r_blinkPhase;

  logic                w_slotLast;
  logic                w_idxLast;
  logic                w_frameStart;
  logic [DIGITS-1:0]   w_blinkOff;
  logic [4*DIGITS-1:0] w_srcDig;
  logic [DIGITS-1:0]   w_srcDp;

  logic [DIGITS-1:0]   w_staticBlank;
  logic [7*DIGITS-1:0] w_staticSeg;
  logic [DIGITS-1:0]   w_staticDp;

  logic [DIGITS-1:0]   w_scanBlank;
  logic [7*DIGITS-1:0] w_scanImgSeg;
  logic [DIGITS-1:0]   w_scanImgDp;
  logic [6:0]          w_scanSeg;
  logic                w_scanDp;
  logic [DIGITS-1:0]   w_scanSel;

  // Hex nibble to active-low g..a segment pattern.
  function automatic logic [6:0] hexToSeg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Leading-zero mask: walk down from the top digit while the nibble is zero
  // and its DP is off. Digit 0 is never part of the walk, so "0" stays visible.
  function automatic logic [DIGITS-1:0] lzMask(
    input logic [4*DIGITS-1:0] dig,
    input logic [DIGITS-1:0]   dp,
    input logic                en
  );
    logic [DIGITS-1:0] mask;
    logic              leading;
    mask    = '0;
    leading = en;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (leading && (dig[4*k +: 4] == 4'h0) && !dp[k]) begin
        mask[k] = 1'b1;
      end else begin
        leading = 1'b0;
      end
    end
    return mask;
  endfunction

  // Segment image for every digit, with blanked digits forced dark.
  function automatic logic [7*DIGITS-1:0] imageSeg(
    input logic [4*DIGITS-1:0] dig,
    input logic [DIGITS-1:0]   blank
  );
    logic [7*DIGITS-1:0] img;
    img = '1;
    for (int k = 0; k < DIGITS; k++) begin
      img[7*k +: 7] = blank[k] ? SEG_BLANK : hexToSeg(dig[4*k +: 4]);
    end
    return img;
  endfunction

  assign w_slotLast   = (r_slot == SLOT_LAST);
  assign w_idxLast    = (r_idx == IDX_LAST);
  assign w_frameStart = (r_slot == '0) && (r_idx == '0);
  assign w_blinkOff   = r_blinkPhase ? io_disp.i_blink : '0;

  // At a frame start the scan reads the held word directly, so the first slot
  // shows the same word the frame copy is being loaded with.
  assign w_srcDig = w_frameStart ? r_heldDig : r_frameDig;
  assign w_srcDp  = w_frameStart ? r_heldDp  : r_frameDp;

  // Static image from the held word: LZ blanking, blink, decode, DP polarity.
  always_comb begin
    w_staticBlank = lzMask(r_heldDig, r_heldDp, io_disp.i_blankLz) | w_blinkOff;
    w_staticSeg   = imageSeg(r_heldDig, w_staticBlank);
    w_staticDp    = w_staticBlank | ~r_heldDp;
  end

  // Scan image from the frame source, then pick out the digit being scanned.
  always_comb begin
    w_scanBlank  = lzMask(w_srcDig, w_srcDp, io_disp.i_blankLz) | w_blinkOff;
    w_scanImgSeg = imageSeg(w_srcDig, w_scanBlank);
    w_scanImgDp  = w_scanBlank | ~w_srcDp;
    w_scanSeg    = SEG_BLANK;
    w_scanDp     = 1'b1;
    w_scanSel    = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_idx == IW'(k)) begin
        w_scanSeg    = w_scanImgSeg[7*k +: 7];
        w_scanDp     = w_scanImgDp[k];
        w_scanSel[k] = 1'b0;
      end
    end
  end

  // Held word: recaptured on every cycle iLOAD is high.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_heldDig <= '0;
      r_heldDp  <= '0;
    end else if (io_disp.i_load) begin
      r_heldDig <= io_disp.i_dig;
      r_heldDp  <= io_disp.i_dp;
    end
  end

  // Blink timebase: phase flips each time the counter wraps.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b0;
    end else if (r_blinkCnt == BLINK_LAST) begin
      r_blinkCnt   <= '0;
      r_blinkPhase <= ~r_blinkPhase;
    end else begin
      r_blinkCnt <= r_blinkCnt + BLINK_ONE;
    end
  end

  // Scan position: slot counter, digit index advancing on each slot wrap.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_slot <= '0;
      r_idx  <= '0;
    end else if (w_slotLast) begin
      r_slot <= '0;
      r_idx  <= w_idxLast ? '0 : (r_idx + IDX_ONE);
    end else begin
      r_slot <= r_slot + SLOT_ONE;
    end
  end

  // Frame copy and registered scan bus; selects stay off during the dead time.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_frameDig        <= '0;
      r_frameDp         <= '0;
      io_disp.o_scanSeg <= '1;
      io_disp.o_scanDp  <= 1'b1;
      io_disp.o_scanSel <= '1;
      io_disp.o_frame   <= 1'b0;
    end else begin
      if (w_frameStart) begin
        r_frameDig <= r_heldDig;
        r_frameDp  <= r_heldDp;
      end
      io_disp.o_frame   <= w_frameStart;
      io_disp.o_scanSeg <= w_scanSeg;
      io_disp.o_scanDp  <= w_scanDp;
      io_disp.o_scanSel <= (r_slot >= SLOT_DEAD) ? w_scanSel : '1;
    end
  end

  // Static view: registered decode of the held word.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      io_disp.o_seg <= '1;
      io_disp.o_dp  <= '1;
    end else begin
      io_disp.o_seg <= w_staticSeg;
      io_disp.o_dp  <= w_staticDp;
    end
  end

endmodule

// File: tb/tb_seg7_scan_n.sv
// Bench for seg7_scan_n with DIGITS=4, SCAN_DIV=8, DEAD=2, BLINK_DIV=64.
// A cycle model driven by "edges since reset" predicts both views every
// cycle; directed steps pin that model with hand-computed literals.
module tb_seg7_scan_n;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 8;
  localparam int DEAD      = 2;
  localparam int BLINK_DIV = 64;
  localparam int FRAME_LEN = DIGITS * SCAN_DIV;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic clk;
  logic rst_n;
  int   testsRun    = 0;
  int   testsFailed = 0;

  seg7_scan_n_if #(.DIGITS(DIGITS)) io();

  seg7_scan_n #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .DEAD     (DEAD),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_disp(io)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net in case something stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] dig, input logic [3:0] dp, input logic load,
                               input logic lz, input logic [3:0] blink);
    io.i_dig     = dig;
    io.i_dp      = dp;
    io.i_load    = load;
    io.i_blankLz = lz;
    io.i_blink   = blink;
  endtask

  task automatic waitFrame(input string name);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 3 * FRAME_LEN && !found; n++) begin
      @(negedge clk);
      found = io.o_frame;
    end
    checkOutput(name, {31'b0, found}, 32'd1);
  endtask

  // Number of leading digits that blanking removes (never digit 0).
  function automatic int leadBlank(input logic [15:0] dig, input logic [3:0] dp);
    int n;
    n = 0;
    while (n < DIGITS - 1 && dig[4*(DIGITS-1-n) +: 4] == 4'h0 && !dp[DIGITS-1-n]) n++;
    return n;
  endfunction

  function automatic logic [27:0] modelSeg(input logic [15:0] dig, input logic [3:0] dp,
                                           input logic lz, input logic [3:0] off);
    logic [27:0] seg;
    int lead;
    lead = lz ? leadBlank(dig, dp) : 0;
    for (int k = 0; k < DIGITS; k++) begin
      if (k >= DIGITS - lead || off[k]) seg[7*k +: 7] = 7'h7F;
      else seg[7*k +: 7] = SEG_TABLE[dig[4*k +: 4]];
    end
    return seg;
  endfunction

  function automatic logic [3:0] modelDp(input logic [15:0] dig, input logic [3:0] dp,
                                         input logic lz, input logic [3:0] off);
    logic [3:0] dpn;
    int lead;
    lead = lz ? leadBlank(dig, dp) : 0;
    for (int k = 0; k < DIGITS; k++) begin
      dpn[k] = (k >= DIGITS - lead || off[k]) ? 1'b1 : ~dp[k];
    end
    return dpn;
  endfunction

  // Model state: held word, frame copy, edges since reset.
  logic [15:0] mHeldDig, mFrameDig;
  logic [3:0]  mHeldDp, mFrameDp;
  int          mS, mC, mIdx, mSlot;
  logic [3:0]  mOff;
  logic [27:0] mImg;
  logic [3:0]  mImgDp;
  logic [27:0] expSeg;
  logic [3:0]  expDp, expSel;
  logic [6:0]  expScanSeg;
  logic        expScanDp, expFrame;

  // Model update at each edge, then compare every output just after it.
  always @(posedge clk) begin
    if (!rst_n) begin
      mHeldDig = '0; mHeldDp = '0; mFrameDig = '0; mFrameDp = '0; mS = 0;
      expSeg = '1; expDp = '1; expSel = '1; expScanSeg = '1; expScanDp = 1'b1; expFrame = 1'b0;
    end else begin
      mC    = mS % FRAME_LEN;
      mIdx  = mC / SCAN_DIV;
      mSlot = mC % SCAN_DIV;
      mOff  = ((mS / BLINK_DIV) % 2 == 1) ? io.i_blink : 4'h0;
      expSeg = modelSeg(mHeldDig, mHeldDp, io.i_blankLz, mOff);
      expDp  = modelDp(mHeldDig, mHeldDp, io.i_blankLz, mOff);
      if (mC == 0) begin
        mFrameDig = mHeldDig;
        mFrameDp  = mHeldDp;
      end
      mImg       = modelSeg(mFrameDig, mFrameDp, io.i_blankLz, mOff);
      mImgDp     = modelDp(mFrameDig, mFrameDp, io.i_blankLz, mOff);
      expScanSeg = mImg[7*mIdx +: 7];
      expScanDp  = mImgDp[mIdx];
      expSel     = (mSlot < DEAD) ? 4'hF : ~(4'b0001 << mIdx);
      expFrame   = (mC == 0);
      if (io.i_load) begin
        mHeldDig = io.i_dig;
        mHeldDp  = io.i_dp;
      end
      mS++;
    end
    #1;
    checkOutput("model_static", {io.o_dp, io.o_seg}, {expDp, expSeg});
    checkOutput("model_scan", {io.o_scanDp, io.o_scanSeg}, {expScanDp, expScanSeg});
    checkOutput("model_sel", io.o_scanSel, expSel);
    checkOutput("model_frame", io.o_frame, expFrame);
  end

  logic [3:0] selTab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  initial begin
    rst_n = 1'b0;
    applyStimulus(16'h0000, 4'h0, 1'b0, 1'b0, 4'h0);

    // Reset state, then first cycle after release.
    repeat (3) @(negedge clk);
    checkOutput("rst_seg", io.o_seg, 28'hFFFFFFF);
    checkOutput("rst_dp", io.o_dp, 4'hF);
    checkOutput("rst_sel", io.o_scanSel, 4'hF);
    checkOutput("rst_frame", io.o_frame, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_seg", io.o_seg, {7'h40, 7'h40, 7'h40, 7'h40});
    checkOutput("first_frame", io.o_frame, 1'b1);
    checkOutput("first_sel", io.o_scanSel, 4'hF);

    // Load 12AF for one cycle.
    applyStimulus(16'h12AF, 4'h0, 1'b1, 1'b0, 4'h0);
    @(negedge clk);
    applyStimulus(16'h12AF, 4'h0, 1'b0, 1'b0, 4'h0);
    @(negedge clk);
    checkOutput("load_seg", io.o_seg, {7'h79, 7'h24, 7'h08, 7'h0E});
    waitFrame("frame1_wait");
    repeat (2) @(negedge clk);
    checkOutput("frame1_scan_seg", io.o_scanSeg, 7'h0E);
    checkOutput("frame1_sel", io.o_scanSel, 4'hE);

    // Leading-zero blanking, without and with a DP stopping it.
    applyStimulus(16'h0030, 4'h0, 1'b1, 1'b1, 4'h0);
    @(negedge clk);
    applyStimulus(16'h0030, 4'h0, 1'b0, 1'b1, 4'h0);
    @(negedge clk);
    checkOutput("lz_seg", io.o_seg, {7'h7F, 7'h7F, 7'h30, 7'h40});
    checkOutput("lz_dp", io.o_dp, 4'hF);
    applyStimulus(16'h0030, 4'b0100, 1'b1, 1'b1, 4'h0);
    @(negedge clk);
    applyStimulus(16'h0030, 4'b0100, 1'b0, 1'b1, 4'h0);
    @(negedge clk);
    checkOutput("lz_dp_seg", io.o_seg, {7'h7F, 7'h40, 7'h30, 7'h40});
    checkOutput("lz_dp_dp", io.o_dp, 4'hB);

    // Scan timing across one full frame.
    waitFrame("scan_wait");
    for (int i = 0; i < FRAME_LEN; i++) begin
      checkOutput("scan_sel", io.o_scanSel, ((i % SCAN_DIV) < DEAD) ? 4'hF : selTab[i / SCAN_DIV]);
      @(negedge clk);
    end
    checkOutput("frame_period", io.o_frame, 1'b1);

    // Mid-frame load at index 2: static follows, scan keeps the old frame.
    repeat (18) @(negedge clk);
    applyStimulus(16'h1111, 4'h0, 1'b1, 1'b1, 4'h0);
    @(negedge clk);
    applyStimulus(16'h1111, 4'h0, 1'b0, 1'b1, 4'h0);
    @(negedge clk);
    checkOutput("midload_seg", io.o_seg, {7'h79, 7'h79, 7'h79, 7'h79});
    checkOutput("old_frame_d2", io.o_scanSeg, 7'h40);
    checkOutput("old_frame_d2_dp", io.o_scanDp, 1'b0);
    repeat (6) @(negedge clk);
    checkOutput("old_frame_d3", io.o_scanSeg, 7'h7F);
    waitFrame("new_frame_wait");
    repeat (2) @(negedge clk);
    checkOutput("new_frame_d0", io.o_scanSeg, 7'h79);
    checkOutput("new_frame_sel", io.o_scanSel, 4'hE);

    // Blink on digit 0; reset during the dark phase restarts the phase.
    applyStimulus(16'h1111, 4'h0, 1'b0, 1'b0, 4'b0001);
    begin
      logic dark;
      dark = 1'b0;
      for (int n = 0; n < 3 * BLINK_DIV && !dark; n++) begin
        @(negedge clk);
        dark = (io.o_seg[6:0] == 7'h7F);
      end
      checkOutput("blink_dark_wait", {31'b0, dark}, 32'd1);
    end
    checkOutput("blink_others", io.o_seg[27:7], {7'h79, 7'h79, 7'h79});
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("blink_rst_seg", io.o_seg, 28'hFFFFFFF);
    checkOutput("blink_rst_sel", io.o_scanSel, 4'hF);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("blink_t1", io.o_seg, {7'h40, 7'h40, 7'h40, 7'h40});
    repeat (63) @(negedge clk);
    checkOutput("blink_t64", io.o_seg[6:0], 7'h40);
    @(negedge clk);
    checkOutput("blink_t65", io.o_seg, {7'h40, 7'h40, 7'h40, 7'h7F});
    repeat (63) @(negedge clk);
    checkOutput("blink_t128", io.o_seg[6:0], 7'h7F);
    @(negedge clk);
    checkOutput("blink_t129", io.o_seg[6:0], 7'h40);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
